sccb_arb: RTL and testbench

SCCB_ARB -- requirements
Module: sccb_arb

---
 rtl/sccb_arb.sv | 216 +++++++++++++++++++++
 tb/tb_sccb_arb.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : sccb_arb
//  Purpose  : Two-requester arbiter in front of a single SCCB/I2C master.
//             Requester 0 (config sequencer) is always eligible. Requester 1
//             (runtime host) is eligible only once cfg_done is high. Ties are
//             broken round-robin. Each transaction has a wait-for-completion
//             timeout, and the block keeps completion and timeout counters.
//  Ports    : sys_clk, sys_rst (async, active-high)
//             cfg_done             - configuration phase complete (level)
//             req/rd/addr/wdata x2 - requester command inputs
//             done/err/rdata x2    - per-requester completion, timeout, read data
//             i2c_start, wr_en, rd_en, byte_addr, wr_data - master command side
//             i2c_end, rd_data     - master completion and read data
//             busy, txn_cnt, err_cnt - status
//  Revision : 1.0 - initial release
// ============================================================================
module sccb_arb #(
    parameter int unsigned TIMEOUT_CYC = 20'd1_000_000,
    parameter int unsigned ADDR_W      = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cfg_done,
    input  logic              req0,
    input  logic              req1,
    input  logic              rd0,
    input  logic              rd1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [7:0]        wdata0,
    input  logic [7:0]        wdata1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [7:0]        rdata0,
    output logic [7:0]        rdata1,
    output logic              i2c_start,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] byte_addr,
    output logic [7:0]        wr_data,
    input  logic              i2c_end,
    input  logic [7:0]        rd_data,
    output logic              busy,
    output logic [15:0]       txn_cnt,
    output logic [7:0]        err_cnt
);

    // Timer counts 0 .. TIMEOUT_CYC-1 while waiting for i2c_end.
    localparam int unsigned c_TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_owner;
    logic                r_rd;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_wdata;
    logic                r_last_gnt;
    logic [c_TMR_W-1:0]  r_timer;
    logic                r_abort;
    logic                r_start;
    logic [7:0]          r_rdata0;
    logic [7:0]          r_rdata1;
    logic [15:0]         r_txn_cnt;
    logic [7:0]          r_err_cnt;

    logic                w_elig1;
    logic                w_grant_vld;
    logic                w_grant_sel;
    logic                w_timeout;

    // Requester 1 is silently held off until configuration has finished.
    assign w_elig1     = req1 & cfg_done;
    assign w_grant_vld = req0 | w_elig1;
    // On a tie the requester that did not win last time is granted;
    // otherwise whichever single requester is eligible.
    assign w_grant_sel = (req0 & w_elig1) ? ~r_last_gnt : w_elig1;
    assign w_timeout   = (r_timer == c_TMR_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        done0       = 1'b0;
        done1       = 1'b0;
        err0        = 1'b0;
        err1        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_grant_vld) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // i2c_end takes priority over a coincident timeout.
                if (i2c_end || w_timeout) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done0       = ~r_owner;
                done1       = r_owner;
                err0        = ~r_owner & r_abort;
                err1        = r_owner & r_abort;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: latched command, timer, read data, counters
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_owner    <= 1'b0;
            r_rd       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_last_gnt <= 1'b1;
            r_timer    <= '0;
            r_abort    <= 1'b0;
            r_start    <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
            r_txn_cnt  <= '0;
            r_err_cnt  <= '0;
        end else begin
            // The start pulse is registered out of START so it appears two
            // edges after the request is first seen in IDLE.
            r_start <= (r_state == ST_START);
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_vld) begin
                        r_owner <= w_grant_sel;
                        r_rd    <= w_grant_sel ? rd1 : rd0;
                        r_addr  <= w_grant_sel ? addr1 : addr0;
                        r_wdata <= w_grant_sel ? wdata1 : wdata0;
                        r_abort <= 1'b0;
                    end
                end
                ST_START: begin
                    r_timer <= '0;
                end
                ST_WAIT: begin
                    if (i2c_end) begin
                        if (r_rd) begin
                            if (r_owner) begin
                                r_rdata1 <= rd_data;
                            end else begin
                                r_rdata0 <= rd_data;
                            end
                        end
                    end else if (w_timeout) begin
                        r_abort <= 1'b1;
                    end else begin
                        r_timer <= r_timer + c_TMR_W'(1);
                    end
                end
                ST_DONE: begin
                    r_last_gnt <= r_owner;
                    r_txn_cnt  <= r_txn_cnt + 16'd1;
                    if (r_abort && (r_err_cnt != 8'hFF)) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Direction follows the latched command; both are low when idle.
    assign wr_en     = busy & ~r_rd;
    assign rd_en     = busy & r_rd;
    assign i2c_start = r_start;
    assign byte_addr = r_addr;
    assign wr_data   = r_wdata;
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;
    assign txn_cnt   = r_txn_cnt;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sccb_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_sccb_arb
//  Purpose  : Self-checking bench for sccb_arb. A stimulus process issues
//             transactions and pushes expectations into a scoreboard queue;
//             a monitor pops and compares on every start/done pulse; a
//             master model answers each start with a per-transaction latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sccb_arb;

    localparam int TO = 16;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        cfg_done = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, rd0 = 1'b0, rd1 = 1'b0;
    logic [15:0] addr0 = '0, addr1 = '0;
    logic [7:0]  wdata0 = '0, wdata1 = '0;
    logic        done0, done1, err0, err1;
    logic [7:0]  rdata0, rdata1;
    logic        i2c_start, wr_en, rd_en;
    logic [15:0] byte_addr;
    logic [7:0]  wr_data;
    logic        i2c_end;
    logic [7:0]  rd_data;
    logic        busy;
    logic [15:0] txn_cnt;
    logic [7:0]  err_cnt;

    sccb_arb #(.TIMEOUT_CYC(TO), .ADDR_W(16)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_done(cfg_done),
        .req0(req0), .req1(req1), .rd0(rd0), .rd1(rd1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1), .i2c_start(i2c_start),
        .wr_en(wr_en), .rd_en(rd_en), .byte_addr(byte_addr), .wr_data(wr_data),
        .i2c_end(i2c_end), .rd_data(rd_data), .busy(busy),
        .txn_cnt(txn_cnt), .err_cnt(err_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // lat: cycle (1-based, counted from the start pulse) in which the master
    // answers; 0 = never answers.
    typedef struct {
        bit          owner;
        bit          rd;
        logic [15:0] addr;
        logic [7:0]  wd;
        int          lat;
        logic [7:0]  ret;
    } txn_t;

    txn_t sb[$];
    txn_t mq[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          m_last  = 1'b1;
    logic [7:0]  m_rdata [2] = '{8'h00, 8'h00};
    int          m_txn   = 0;
    int          m_err   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_err(input int lat);
        return (lat == 0) || (lat > TO);
    endfunction

    function automatic txn_t rnd_txn(input bit owner);
        txn_t t;
        t.owner = owner;
        t.rd    = 1'($urandom_range(0, 1));
        t.addr  = {owner, 15'($urandom)};
        t.wd    = 8'($urandom);
        t.ret   = 8'($urandom);
        case ($urandom_range(0, 9))
            0:       t.lat = 0;
            1:       t.lat = TO + 1;
            2:       t.lat = TO + 2;
            3:       t.lat = TO;
            default: t.lat = int'($urandom_range(1, TO));
        endcase
        return t;
    endfunction

    // Queue the expectation and present the command on the owner's port.
    task automatic issue(input txn_t t);
        sb.push_back(t);
        mq.push_back(t);
        m_last = t.owner;
        if (t.owner == 1'b0) begin
            rd0 = t.rd; addr0 = t.addr; wdata0 = t.wd;
        end else begin
            rd1 = t.rd; addr1 = t.addr; wdata1 = t.wd;
        end
    endtask

    task automatic model_reset();
        sb.delete();
        mq.delete();
        m_last  = 1'b1;
        m_txn   = 0;
        m_err   = 0;
        m_rdata = '{8'h00, 8'h00};
    endtask

    // Wait for n done pulses. keep=1 leaves requests asserted between
    // completions; early=1 drops requests right after the grant.
    task automatic wait_dones(input int n, input bit keep, input bit early);
        int got = 0;
        int k   = 0;
        while (got < n && k < 40 * n + 20) begin
            @(negedge sys_clk);
            k++;
            if (k == 2) chk("start_latency", i2c_start, 1'b1);
            if (early && k == 2) begin req0 = 1'b0; req1 = 1'b0; end
            if (done0 || done1) begin
                got++;
                if (keep) begin
                    if (got == n) begin req0 = 1'b0; req1 = 1'b0; end
                end else begin
                    if (done0) req0 = 1'b0;
                    if (done1) req1 = 1'b0;
                end
            end
        end
        if (got < n) begin
            chk("done_wait_expired", got, n);
            req0 = 1'b0; req1 = 1'b0;
        end
        @(negedge sys_clk);
    endtask

    // ------------------------------------------------------------------
    // Master model
    // ------------------------------------------------------------------
    initial begin
        txn_t t;
        i2c_end = 1'b0;
        rd_data = 8'h00;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst && i2c_start && mq.size() > 0) begin
                t = mq.pop_front();
                if (t.lat > 0) begin
                    repeat (t.lat - 1) @(negedge sys_clk);
                    rd_data = t.ret;
                    i2c_end = 1'b1;
                    @(negedge sys_clk);
                    i2c_end = 1'b0;
                    rd_data = 8'($urandom);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin
        txn_t e;
        bit   er;
        bit   cnt_pend  = 1'b0;
        int   start_cyc = 0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst) begin
                cnt_pend = 1'b0;
                continue;
            end
            if (cnt_pend) begin
                chk("txn_cnt", txn_cnt, m_txn);
                chk("err_cnt", err_cnt, m_err);
                cnt_pend = 1'b0;
            end
            if (i2c_start) begin
                if (sb.size() == 0) begin
                    chk("unexpected_start", i2c_start, 1'b0);
                end else begin
                    e = sb[0];
                    start_cyc = cyc;
                    chk("start_fields",
                        {busy, byte_addr, wr_en, rd_en, (e.rd ? 8'h00 : wr_data)},
                        {1'b1, e.addr, !e.rd, e.rd, (e.rd ? 8'h00 : e.wd)});
                end
            end
            if (done0 || done1 || err0 || err1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", {err1, err0, done1, done0}, 4'h0);
                end else begin
                    e  = sb.pop_front();
                    er = exp_err(e.lat);
                    if (e.rd && !er) m_rdata[e.owner] = e.ret;
                    m_txn = (m_txn + 1) & 16'hFFFF;
                    if (er && m_err < 255) m_err++;
                    chk("done_owner", {done1, done0, err1, err0},
                        {e.owner, !e.owner, e.owner & er, !e.owner & er});
                    chk("rdata", {rdata1, rdata0}, {m_rdata[1], m_rdata[0]});
                    chk("done_latency", cyc - start_cyc, er ? TO : e.lat);
                    chk("hold_fields", {busy, byte_addr, wr_en, rd_en},
                        {1'b1, e.addr, !e.rd, e.rd});
                    cnt_pend = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        txn_t t0, t1;
        bit   first;

        // Reset values while reset is held
        #12;
        chk("reset_ctrl", {busy, done0, done1, err0, err1, i2c_start, wr_en, rd_en}, 8'h00);
        chk("reset_data", {byte_addr, wr_data, rdata0, rdata1, txn_cnt, err_cnt}, 64'h0);
        @(negedge sys_clk);
        sys_rst = 1'b0;

        // Config phase: requester 1 is held off until cfg_done
        t0 = '{owner: 1'b0, rd: 1'b0, addr: 16'h3008, wd: 8'h82, lat: 5, ret: 8'h11};
        issue(t0);
        t1 = rnd_txn(1'b1);
        rd1 = t1.rd; addr1 = t1.addr; wdata1 = t1.wd;
        req0 = 1'b1; req1 = 1'b1;
        wait_dones(1, 1'b0, 1'b0);
        repeat (10) @(negedge sys_clk);
        chk("req1_held_off", busy, 1'b0);
        issue(t1);
        cfg_done = 1'b1;
        wait_dones(1, 1'b0, 1'b0);

        // Fresh reset, then both requesting continuously: grants 0,1,0,1
        sys_rst = 1'b1;
        model_reset();
        @(negedge sys_clk);
        sys_rst = 1'b0;
        t0 = rnd_txn(1'b0);
        t1 = rnd_txn(1'b1);
        issue(t0); issue(t1); issue(t0); issue(t1);
        req0 = 1'b1; req1 = 1'b1;
        wait_dones(4, 1'b1, 1'b0);
        chk("txn_cnt_after_four", txn_cnt, 16'd4);

        // Reads: requester 0 then requester 1 (0x300A -> 0x56)
        t0 = '{owner: 1'b0, rd: 1'b1, addr: 16'h1234, wd: 8'h00, lat: 2, ret: 8'hA5};
        issue(t0); req0 = 1'b1;
        wait_dones(1, 1'b0, 1'b0);
        t1 = '{owner: 1'b1, rd: 1'b1, addr: 16'h300A, wd: 8'h00, lat: 4, ret: 8'h56};
        issue(t1); req1 = 1'b1;
        wait_dones(1, 1'b0, 1'b0);
        chk("rdata1_read", rdata1, 8'h56);
        chk("rdata0_kept", rdata0, 8'hA5);

        // i2c_end coincident with the timeout: no error
        t0 = rnd_txn(1'b0);
        t0.lat = TO;
        issue(t0); req0 = 1'b1;
        wait_dones(1, 1'b0, 1'b0);

        // Randomized rounds
        for (int r = 0; r < 40; r++) begin
            case ($urandom_range(0, 2))
                0: begin
                    issue(rnd_txn(1'b0)); req0 = 1'b1;
                    wait_dones(1, 1'b0, 1'($urandom_range(0, 1)));
                end
                1: begin
                    issue(rnd_txn(1'b1)); req1 = 1'b1;
                    wait_dones(1, 1'b0, 1'($urandom_range(0, 1)));
                end
                default: begin
                    first = ~m_last;
                    issue(rnd_txn(first));
                    issue(rnd_txn(~first));
                    req0 = 1'b1; req1 = 1'b1;
                    wait_dones(2, 1'b0, 1'b0);
                end
            endcase
        end

        // Timeouts until the error counter saturates
        for (int i = 0; i < 260; i++) begin
            t0 = rnd_txn(1'b0);
            t0.lat = 0;
            issue(t0); req0 = 1'b1;
            wait_dones(1, 1'b0, 1'(i % 2));
        end
        chk("err_cnt_saturated", err_cnt, 8'hFF);

        // Reset during WAIT: abandon without done; tie then goes to 0
        t0 = rnd_txn(1'b0);
        t0.lat = 3;
        issue(t0); req0 = 1'b1;
        wait_dones(1, 1'b0, 1'b0);
        t1 = rnd_txn(1'b1);
        t1.lat = 0;
        issue(t1);
        t0 = rnd_txn(1'b0);
        rd0 = t0.rd; addr0 = t0.addr; wdata0 = t0.wd;
        req0 = 1'b1; req1 = 1'b1;
        repeat (5) @(negedge sys_clk);
        #2 sys_rst = 1'b1;
        #1;
        chk("midrst_ctrl", {busy, done0, done1, err0, err1, i2c_start, wr_en, rd_en}, 8'h00);
        chk("midrst_data", {byte_addr, wr_data, rdata0, rdata1, txn_cnt, err_cnt}, 64'h0);
        req0 = 1'b0; req1 = 1'b0;
        model_reset();
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        t0 = rnd_txn(1'b0); t0.lat = 4;
        t1 = rnd_txn(1'b1); t1.lat = 6;
        issue(t0); issue(t1);
        req0 = 1'b1; req1 = 1'b1;
        wait_dones(2, 1'b0, 1'b0);
        repeat (3) @(negedge sys_clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
